switch_input: RTL



---
 rtl/switch_input_if.sv | 12 +
 rtl/switch_input.sv | 103 ++++++++++
 2 files changed

// File: rtl/switch_input_if.sv
// rtl/switch_input_if.sv - CPU peripheral bus bundle (we/addr/in/out) for the switch input block
interface switch_input_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

  modport master (output we, addr, in, input out);
  modport slave  (input we, addr, in, output out);
endinterface

// File: rtl/switch_input.sv
// rtl/switch_input.sv - synchronised, debounced switch input register block; SWITCH_IRQ_EN adds MASK and irq
module switch_input #(
  parameter int WIDTH    = 32,
  parameter int TICK_DIV = 50000,
  parameter int STABLE   = 3
) (
  input  logic             clk,
  input  logic             reset,
  switch_input_if.slave    bus,
  input  logic [WIDTH-1:0] sw_in,
  output logic             irq
);

  localparam int         PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] STABLE_M1 = 4'(STABLE - 1);

  logic [WIDTH-1:0]      s1, s2;
  logic [WIDTH-1:0]      value, value_next;
  logic [WIDTH-1:0]      flags, flags_next;
  logic [WIDTH-1:0]      set_bits, clr_bits;
  logic [WIDTH-1:0][3:0] cnt, cnt_next;
  logic [WIDTH-1:0]      mask;
  logic [PW-1:0]         presc;
  logic                  tick;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // A tick that sees the input agree with VALUE restarts that bit's count.
  always_comb begin
    value_next = value;
    cnt_next   = cnt;
    set_bits   = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == value[i]) begin
          cnt_next[i] = 4'd0;
        end else if (cnt[i] == STABLE_M1) begin
          value_next[i] = s2[i];
          cnt_next[i]   = 4'd0;
          set_bits[i]   = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // OR-ing set after the clear lets a same-cycle debounce win over W1C.
  always_comb begin
    clr_bits   = (bus.we && bus.addr == 2'd1) ? bus.in : '0;
    flags_next = (flags & ~clr_bits) | set_bits;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      value <= '0;
      flags <= '0;
      cnt   <= '0;
      presc <= '0;
    end else begin
      s1    <= sw_in;
      s2    <= s1;
      value <= value_next;
      flags <= flags_next;
      cnt   <= cnt_next;
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

`ifdef SWITCH_IRQ_EN
  logic [WIDTH-1:0] mask_next;

  always_comb begin
    mask_next = (bus.we && bus.addr == 2'd2) ? bus.in : mask;
  end

  // irq looks at next-state values so it lands on the same edge as the flag/mask update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      mask <= mask_next;
      irq  <= |(flags_next & mask_next);
    end
  end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    case (bus.addr)
      2'd0:    bus.out = value;
      2'd1:    bus.out = flags;
      2'd2:    bus.out = mask;
      default: bus.out = '0;
    endcase
  end

endmodule
